if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter NOP_INST, default 32'h00000000, instruction word delivered with a fetch exception.
REQ-002 Parameter EXC_ADEL, default 5'd4, exception code for a misaligned fetch.
REQ-003 Parameter EXC_IBE, default 5'd6, exception code for an instruction bus error.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 pc_addr  in  32  current fetch address from the pc stage.
REQ-007 redirect  in  1  branch or exception redirect of pc on this edge.
REQ-008 id_stall  in  1  decode is not accepting the output slot this cycle.
REQ-009 pc_enable  out  1  advance/redirect permission to the pc stage.
REQ-010 ibus_req  out  1  registered instruction bus request.
REQ-011 ibus_addr  out  32  registered request address, word aligned.
REQ-012 ibus_ack  in  1  request completes this cycle.
REQ-013 ibus_rdata  in  32  read data; valid only with ibus_ack.
REQ-014 ibus_err  in  1  bus error; valid only with ibus_ack.
REQ-015 inst_valid / inst / inst_pc  out  1/32/32  output slot to decode.
REQ-016 inst_exc / inst_exc_code  out  1/5  fetch exception flag and code.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE (nothing outstanding), WAIT (request outstanding), DROP (outstanding request to discard).
REQ-018 In IDLE with the skid buffer empty, redirect=0, and pc_addr[1:0]=0, the block SHALL latch ibus_addr<=pc_addr and ibus_req<=1, then enter WAIT.
REQ-019 In IDLE with the skid buffer empty, redirect=0, and pc_addr[1:0]!=0, the block SHALL issue no request and SHALL complete a result with inst=NOP_INST, inst_exc=1, inst_exc_code=EXC_ADEL, inst_pc=pc_addr, and pc_enable=1 for that cycle.
REQ-020 In WAIT, ibus_req and ibus_addr SHALL remain stable until the cycle in which ibus_ack=1.
REQ-021 On ibus_ack in WAIT with redirect=0, the block SHALL complete a result, drop ibus_req, and return to IDLE; ibus_err=1 SHALL yield NOP_INST/inst_exc=1/EXC_IBE.
REQ-022 pc_enable SHALL be combinational: 1 when a result completes (REQ-019/021) or redirect=1, else 0; pc_addr is therefore stable throughout WAIT.
REQ-023 A completed result SHALL load the output slot when the slot is empty or id_stall=0; otherwise it SHALL load the one-entry skid buffer.
REQ-024 When id_stall=0, the slot SHALL refill from the skid buffer if the buffer is full, otherwise from a completing result, otherwise it SHALL clear inst_valid.
REQ-025 No new request SHALL be issued while the skid buffer is full; the buffer SHALL never overflow.
REQ-026 redirect=1 in WAIT without ibus_ack SHALL move to DROP; redirect=1 with ibus_ack SHALL discard the data and move to IDLE.
REQ-027 In DROP, ibus_req SHALL stay asserted until ibus_ack; the data SHALL be discarded, the FSM SHALL go to IDLE, and no pc_enable pulse SHALL result.
REQ-028 redirect=1 SHALL clear inst_valid and the skid buffer on the same edge, regardless of id_stall.
REQ-029 Minimum throughput SHALL be one instruction per two cycles when ibus_ack arrives in the first WAIT cycle.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously force: state=IDLE, ibus_req=0, ibus_addr=0, inst_valid=0, inst=NOP_INST, inst_pc=0, inst_exc=0, inst_exc_code=0, skid buffer empty.
REQ-031 Reset asserted during WAIT SHALL abandon the request; any ibus_ack after reset release SHALL be ignored in IDLE.

Structure
REQ-032 FSM state encodings and the EXC_ADEL/EXC_IBE codes SHALL live in the shared CPU defines header, also used by the exception unit.
REQ-033 The skid buffer SHALL be a sub-module if_skid_buf (valid, inst, pc, exc, code; load/pop/clear); everything else stays in if_fetch.

Verification
REQ-034 Reset release with pc_addr=32'hbfc00000 -> next cycle ibus_req=1, ibus_addr=32'hbfc00000; ack with rdata=32'h24020001 -> pc_enable=1, inst=32'h24020001, inst_pc=32'hbfc00000.
REQ-035 Hold ibus_ack low for 5 cycles -> ibus_addr constant and pc_enable=0 throughout; ack -> exactly one pc_enable pulse.
REQ-036 id_stall=1 with slot full, then ack -> skid buffer loads, no new request; release id_stall -> buffered word appears, then a new request issues.
REQ-037 Redirect during WAIT, then ack two cycles later -> data discarded, inst_valid=0, next request uses the redirected pc_addr.
REQ-038 pc_addr=32'hbfc00002 -> no ibus_req; inst_exc=1, code=4, inst=NOP_INST; ack with ibus_err=1 -> code=6.
REQ-039 rst_n low mid-WAIT -> ibus_req=0 immediately; a late ack produces no inst_valid.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared CPU defines for the fetch stage and the exception unit.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [4:0] EXC_ADEL_CODE = 5'd4;
    localparam logic [4:0] EXC_IBE_CODE  = 5'd6;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  code;
    } fetch_res_t;

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding register for a fetch result that decode could not accept.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       pop,
    input  logic       clear,
    input  fetch_res_t load_data,
    output logic       valid,
    output fetch_res_t data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage; issues one bus request at a time and delivers results
// to decode through an output slot backed by a one-entry skid buffer.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h00000000,
    parameter logic [4:0]  EXC_ADEL = EXC_ADEL_CODE,
    parameter logic [4:0]  EXC_IBE  = EXC_IBE_CODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_addr,
    input  logic        redirect,
    input  logic        id_stall,
    output logic        pc_enable,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_err,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_exc,
    output logic [4:0]  inst_exc_code
);

    fetch_state_t state;
    fetch_res_t   res;
    fetch_res_t   skid;
    fetch_res_t   src;
    logic         skid_valid;
    logic         issue_ok;
    logic         misaligned;
    logic         complete;
    logic         slot_load;

    always_comb begin
        issue_ok   = state == S_IDLE && !skid_valid && !redirect;
        misaligned = pc_addr[1:0] != 2'b00;
        complete   = (issue_ok && misaligned) || (state == S_WAIT && ibus_ack && !redirect);
        res.inst   = (state == S_WAIT && !ibus_err) ? ibus_rdata : NOP_INST;
        res.pc     = state == S_WAIT ? ibus_addr : pc_addr;
        res.exc    = state != S_WAIT || ibus_err;
        res.code   = state != S_WAIT ? EXC_ADEL : (ibus_err ? EXC_IBE : 5'd0);
        pc_enable  = complete || redirect;
        slot_load  = !redirect && (!id_stall || !inst_valid);
        src        = skid_valid ? skid : res;
    end

    if_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete && inst_valid && id_stall),
        .pop       (skid_valid && !id_stall),
        .clear     (redirect),
        .load_data (res),
        .valid     (skid_valid),
        .data      (skid)
    );

    // A redirect while waiting cannot cancel the bus cycle, so DROP swallows its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ibus_req  <= 1'b0;
            ibus_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (issue_ok && !misaligned) begin
                    ibus_req  <= 1'b1;
                    ibus_addr <= {pc_addr[31:2], 2'b00};
                    state     <= S_WAIT;
                end
                S_WAIT: if (ibus_ack) begin
                    ibus_req <= 1'b0;
                    state    <= S_IDLE;
                end else if (redirect) begin
                    state <= S_DROP;
                end
                S_DROP: if (ibus_ack) begin
                    ibus_req <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid    <= 1'b0;
            inst          <= NOP_INST;
            inst_pc       <= '0;
            inst_exc      <= 1'b0;
            inst_exc_code <= '0;
        end else if (redirect) begin
            inst_valid <= 1'b0;
        end else if (slot_load) begin
            inst_valid <= skid_valid || complete;
            if (skid_valid || complete) begin
                inst          <= src.inst;
                inst_pc       <= src.pc;
                inst_exc      <= src.exc;
                inst_exc_code <= src.code;
            end
        end
    end

endmodule
